// File: rtl/noc_pkg.sv
// noc_pkg: address, flit type and head-field layout shared by leaf and spine
package noc_pkg;
  localparam int ADDR_W = 6;
  localparam int GROUP_W = 4;
  localparam int LEAF_W = 2;
  localparam int LEN_W = 4;
  localparam int NUM_GROUPS = 8;
  localparam int HEAD_W = 16;
  localparam int HEAD_LEN_LSB = 0;
  localparam int HEAD_DEST_LSB = 4;
  localparam int HEAD_SRC_LSB = 10;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  typedef enum logic [1:0] {IDLE, HEAD, BODY} pkt_state_e;
  function automatic logic [HEAD_W-1:0] head_fields(input logic [ADDR_W-1:0] src, dst, input logic [LEN_W-1:0] len);
    return {src, dst, len};
  endfunction
endpackage

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: saturating credit count for a credit-based link
module noc_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dec,
  input  logic                         inc,
  output logic [$clog2(CREDITS+1)-1:0] count,
  output logic                         has_credit
);
  localparam int CW = $clog2(CREDITS+1);
  logic take_inc;
  // a return at full is dropped unless a send frees a slot the same cycle
  assign take_inc = inc && (count != CW'(CREDITS) || dec);
  assign has_credit = count != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= CW'(CREDITS);
    else count <= count - CW'(dec) + CW'(take_inc);
endmodule

// File: rtl/leaf_uplink_packetizer.sv
// leaf_uplink_packetizer: turns send requests plus payload into head/body/tail flits on a credit uplink
module leaf_uplink_packetizer
  import noc_pkg::*;
#(
  parameter logic [GROUP_W-1:0] GROUP_ID = 4'b0101,
  parameter logic [LEAF_W-1:0]  LEAF_ID  = 2'b00,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 8,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_dest,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [DATA_W-1:0] pld_data,
  output logic              flit_valid,
  output logic [DATA_W+1:0] flit_data,
  input  logic              credit_return,
  output logic              err_drop,
  output logic              busy
);
  localparam int CW = $clog2(CREDITS+1);
  pkt_state_e state;
  logic [ADDR_W-1:0] dest;
  logic [LEN_W-1:0] len, remaining;
  logic [CW-1:0] credit_cnt;
  logic has_credit, send_head, send_body, legal;
  assign req_ready = state == IDLE;
  assign pld_ready = state == BODY && has_credit;
  assign busy = state != IDLE;
  assign send_head = state == HEAD && has_credit;
  assign send_body = pld_valid && pld_ready;
  assign legal = req_dest[ADDR_W-1:LEAF_W] != '0 && req_dest[ADDR_W-1:LEAF_W] <= GROUP_W'(NUM_GROUPS)
              && req_len != '0 && req_len <= LEN_W'(MAX_LEN);
  noc_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk(clk), .rst_n(rst_n), .dec(send_head || send_body), .inc(credit_return),
    .count(credit_cnt), .has_credit(has_credit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dest <= '0;
      len <= '0;
      remaining <= '0;
      flit_valid <= 1'b0;
      flit_data <= '0;
      err_drop <= 1'b0;
    end else begin
      flit_valid <= send_head || send_body;
      err_drop <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          dest <= req_dest;
          len <= req_len;
          err_drop <= !legal;
          if (legal) state <= HEAD;
        end
        HEAD: if (has_credit) begin
          flit_data <= {FLIT_HEAD, DATA_W'(head_fields({GROUP_ID, LEAF_ID}, dest, len))};
          remaining <= len;
          state <= BODY;
        end
        BODY: if (send_body) begin
          flit_data <= {(remaining == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY, pld_data};
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_leaf_uplink_packetizer.sv
// tb_leaf_uplink_packetizer: scoreboard bench for the leaf uplink packetizer
module tb_leaf_uplink_packetizer;
  logic clk = 0, rst_n = 0, req_valid = 0, pld_valid = 0, credit_return = 0;
  logic [5:0] req_dest = '0;
  logic [3:0] req_len = '0;
  logic [31:0] pld_data = '0;
  logic req_ready, pld_ready, flit_valid, err_drop, busy;
  logic [33:0] flit_data;
  logic [33:0] sb[$];
  int checks = 0, errors = 0, nflits = 0, ndrops = 0;

  leaf_uplink_packetizer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_len(req_len), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .pld_data(pld_data), .flit_valid(flit_valid), .flit_data(flit_data),
    .credit_return(credit_return), .err_drop(err_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (flit_valid) begin
      nflits++;
      if (sb.size() == 0) check("sb_depth", 64'(sb.size()), 64'd1);
      else check("flit", flit_data, sb.pop_front());
    end
    if (err_drop) ndrops++;
  end

  task automatic do_reset();
    rst_n = 0; req_valid = 0; pld_valid = 0; credit_return = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic send_req(input logic [5:0] d, input logic [3:0] l, input bit legal);
    int n;
    @(posedge clk); #1;
    req_valid = 1; req_dest = d; req_len = l; n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    check("req_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    if (legal) sb.push_back({2'b01, 16'h0, 4'b0101, 2'b00, d, l});
  endtask

  task automatic send_pld(input logic [31:0] w, input bit last, output int waits);
    pld_valid = 1; pld_data = w; waits = 0;
    @(negedge clk);
    while (!pld_ready && waits < 50) begin waits++; @(negedge clk); end
    check("pld_ready", pld_ready, 1);
    @(posedge clk); #1;
    sb.push_back({last ? 2'b10 : 2'b00, w});
  endtask

  task automatic send_pkt(input logic [5:0] d, input logic [3:0] l, input logic [31:0] base, output int stalls);
    int w;
    stalls = 0;
    send_req(d, l, 1);
    for (int i = 0; i < int'(l); i++) begin
      send_pld(base + 32'(i), i == int'(l) - 1, w);
      if (i > 0) stalls += w;
    end
    pld_valid = 0;
  endtask

  task automatic pulse_credit();
    @(posedge clk); #1 credit_return = 1;
    @(posedge clk); #1 credit_return = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [5:0] bad_dest [3] = '{6'b0000_01, 6'b1001_00, 6'b0011_00};
  logic [3:0] bad_len [3] = '{4'd3, 4'd3, 4'd0};

  initial begin
    int st, w, n0, d0;
    do_reset();
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_data", flit_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_drop, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_pld_ready", pld_ready, 0);
    check("rst_credits", dut.credit_cnt, 4);

    send_pkt(6'b0011_10, 3, 32'hA0, st);
    check("t1_stalls", st, 0);
    @(negedge clk); #1;
    check("t1_busy", busy, 0);
    check("t1_credits", dut.credit_cnt, 0);
    check("t1_nflits", nflits, 4);

    do_reset();
    send_req(6'b0100_01, 5, 1);
    for (int i = 0; i < 3; i++) send_pld(32'hB0 + 32'(i), 0, w);
    for (int k = 3; k < 5; k++) begin
      pld_valid = 1; pld_data = 32'hB0 + 32'(k);
      repeat (3) @(negedge clk);
      check("t2_stall_ready", pld_ready, 0);
      check("t2_stall_busy", busy, 1);
      pulse_credit();
      send_pld(32'hB0 + 32'(k), k == 4, w);
      check("t2_resume", w, 0);
    end
    pld_valid = 0;
    @(negedge clk); #1;
    check("t2_busy", busy, 0);

    n0 = nflits; d0 = ndrops;
    for (int i = 0; i < 3; i++) begin
      send_req(bad_dest[i], bad_len[i], 0);
      check("t3_err", err_drop, 1);
      check("t3_pld_ready", pld_ready, 0);
      check("t3_busy", busy, 0);
      @(posedge clk); #1;
      check("t3_err_pulse", err_drop, 0);
    end
    check("t3_noflit", nflits, n0);
    @(negedge clk); #1;
    check("t3_drops", ndrops, d0 + 3);

    do_reset();
    send_pkt(6'b0010_10, 3, 32'hC0, st);
    pulse_credit();
    pulse_credit();
    check("t4_credits2", dut.credit_cnt, 2);
    send_req(6'b0110_11, 3, 1);
    @(posedge clk); #1;
    check("t4_after_head", dut.credit_cnt, 1);
    credit_return = 1;
    for (int i = 0; i < 3; i++) begin
      send_pld(32'hC8 + 32'(i), i == 2, w);
      check("t4_nostall", w, 0);
      check("t4_credits", dut.credit_cnt, 1);
    end
    credit_return = 0; pld_valid = 0;

    do_reset();
    send_req(6'b0111_00, 3, 1);
    send_pld(32'hD0, 0, w);
    pld_valid = 0;
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    check("t5_flit_valid", flit_valid, 0);
    check("t5_flit_data", flit_data, 0);
    check("t5_busy", busy, 0);
    check("t5_credits", dut.credit_cnt, 4);
    check("t5_sb", 64'(sb.size()), 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    send_pkt(6'b1000_11, 2, 32'hE0, st);
    @(negedge clk); #1;
    check("t5_restart_credits", dut.credit_cnt, 1);
    check("t5_restart_busy", busy, 0);

    do_reset();
    pulse_credit();
    check("t6_saturate", dut.credit_cnt, 4);
    credit_return = 1;
    send_pkt(6'b0001_01, 8, 32'hF0, st);
    credit_return = 0;
    check("t6_maxlen_stalls", st, 0);
    @(negedge clk); #1;
    check("t6_credits", dut.credit_cnt, 4);
    check("t6_busy", busy, 0);
    d0 = ndrops;
    send_req(6'b0001_01, 9, 0);
    @(negedge clk); #1;
    check("t6_len9_drop", ndrops, d0 + 1);
    check("t6_len9_busy", busy, 0);
    check("sb_empty", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
